// File: rtl/keypad_scanner_if.sv
// Keypad-side and strobe-side signals of the keypad scanner.
// The master modport is the scanner; the slave modport is the keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       b_0, b_1, b_2, b_3, b_4, b_5, b_6, b_7;
  logic       b_8, b_9, b_a, b_b, b_c, b_d, b_e, b_f;
  logic       key_down;
  logic [3:0] key_code;

  modport master (
    input  row_n,
    output col_n,
    output b_0, b_1, b_2, b_3, b_4, b_5, b_6, b_7,
    output b_8, b_9, b_a, b_b, b_c, b_d, b_e, b_f,
    output key_down, key_code
  );

  modport slave (
    output row_n,
    input  col_n,
    input  b_0, b_1, b_2, b_3, b_4, b_5, b_6, b_7,
    input  b_8, b_9, b_a, b_b, b_c, b_d, b_e, b_f,
    input  key_down, key_code
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce; emits one
// single-cycle hex strobe per accepted key press.
module keypad_scanner #(
  parameter int SCAN_DIV         = 1000,
  parameter int DEBOUNCE_SAMPLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scanner_if.master  kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

  logic [3:0]       row_p0, row_p1;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0]      strobe_q, strobe_d;
  logic             key_down_q, key_down_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             any_low, cand_low;
  logic [1:0]       low_row;
  logic             accept, release_done;
  logic [1:0]       acc_row;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_p0 <= 4'hF;
      row_p1 <= 4'hF;
    end else begin
      row_p0 <= kp.row_n;
      row_p1 <= row_p0;
    end
  end

  // Free-running divider; never restarted by state changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign tick     = (div_q == DIV_W'(SCAN_DIV - 1));
  assign any_low  = ~&row_p1;
  assign cand_low = ~row_p1[cand_q];
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    low_row = 2'd3;
    if      (!row_p1[0]) low_row = 2'd0;
    else if (!row_p1[1]) low_row = 2'd1;
    else if (!row_p1[2]) low_row = 2'd2;
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    strobe_d     = '0;
    key_down_d   = key_down_q;
    key_code_d   = key_code_q;
    accept       = 1'b0;
    release_done = 1'b0;
    acc_row      = cand_q;

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (any_low) begin
            cand_d  = low_row;
            acc_row = low_row;
            cnt_d   = CNT_W'(1);
            if (DEBOUNCE_SAMPLES == 1) accept = 1'b1;
            else                       state_d = PRESS_DB;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        PRESS_DB: begin
          if (cand_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_SAMPLES)) accept = 1'b1;
          end else begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        HELD: begin
          if (!cand_low) begin
            cnt_d = CNT_W'(1);
            if (DEBOUNCE_SAMPLES == 1) release_done = 1'b1;
            else                       state_d = REL_DB;
          end
        end
        REL_DB: begin
          if (!cand_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE_SAMPLES)) release_done = 1'b1;
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    if (accept) begin
      state_d    = HELD;
      key_code_d = key_map(acc_row, col_q);
      key_down_d = 1'b1;
      strobe_d   = 16'(1) << key_code_d;
    end
    if (release_done) begin
      state_d    = SCAN;
      key_down_d = 1'b0;
      col_d      = col_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      col_q      <= 2'd0;
      cand_q     <= 2'd0;
      cnt_q      <= '0;
      strobe_q   <= '0;
      key_down_q <= 1'b0;
      key_code_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      strobe_q   <= strobe_d;
      key_down_q <= key_down_d;
      key_code_q <= key_code_d;
    end
  end

  assign kp.col_n    = ~(4'b0001 << col_q);
  assign kp.key_down = key_down_q;
  assign kp.key_code = key_code_q;
  assign kp.b_0 = strobe_q[0];
  assign kp.b_1 = strobe_q[1];
  assign kp.b_2 = strobe_q[2];
  assign kp.b_3 = strobe_q[3];
  assign kp.b_4 = strobe_q[4];
  assign kp.b_5 = strobe_q[5];
  assign kp.b_6 = strobe_q[6];
  assign kp.b_7 = strobe_q[7];
  assign kp.b_8 = strobe_q[8];
  assign kp.b_9 = strobe_q[9];
  assign kp.b_a = strobe_q[10];
  assign kp.b_b = strobe_q[11];
  assign kp.b_c = strobe_q[12];
  assign kp.b_d = strobe_q[13];
  assign kp.b_e = strobe_q[14];
  assign kp.b_f = strobe_q[15];

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: table of single-key presses plus
// hand-written reset, bounce, two-key and reset-while-held sequences.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [15:0] keys;  // bit r*4+c closes (row r, col c)

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SAMPLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp.master)
  );

  assign kp.row_n = {~|(keys[15:12] & ~kp.col_n), ~|(keys[11:8] & ~kp.col_n),
                     ~|(keys[7:4]   & ~kp.col_n), ~|(keys[3:0]  & ~kp.col_n)};

  wire [15:0] b_vec = {kp.b_f, kp.b_e, kp.b_d, kp.b_c, kp.b_b, kp.b_a, kp.b_9, kp.b_8,
                       kp.b_7, kp.b_6, kp.b_5, kp.b_4, kp.b_3, kp.b_2, kp.b_1, kp.b_0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_fail;
  int hi_cnt [16];
  int snap   [16];
  int multi_hot, kd_hi, kd_snap;
  int cyc;

  initial begin
    for (int i = 0; i < 16; i++) hi_cnt[i] = 0;
    multi_hot = 0;
    kd_hi     = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 16; i++)
        if (b_vec[i]) hi_cnt[i] <= hi_cnt[i] + 1;
      if ($countones(b_vec) > 1) multi_hot <= multi_hot + 1;
      if (kp.key_down) kd_hi <= kd_hi + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic take_snap();
    for (int i = 0; i < 16; i++) snap[i] = hi_cnt[i];
    kd_snap = kd_hi;
  endtask

  function automatic int delta(input int i);
    return hi_cnt[i] - snap[i];
  endfunction

  function automatic int total_delta();
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) s += hi_cnt[i] - snap[i];
    return s;
  endfunction

  typedef struct {
    int         row;
    int         col;
    int         hold;
    logic [3:0] exp_code;
    int         exp_pulses;
  } vec_t;

  vec_t       tbl [8];
  logic [3:0] exp_cols [4];
  int         p, t, fall_cyc;
  logic       found;
  logic [3:0] c0;

  initial begin
    tbl[0] = '{0, 0, 100, 4'h1, 1};
    tbl[1] = '{0, 1, 100, 4'h2, 1};
    tbl[2] = '{1, 3, 100, 4'hB, 1};
    tbl[3] = '{2, 2, 100, 4'h9, 1};
    tbl[4] = '{3, 0, 100, 4'hE, 1};
    tbl[5] = '{3, 3, 100, 4'hD, 1};
    tbl[6] = '{2, 1, 100, 4'h8, 1};
    tbl[7] = '{3, 2, 12,  4'h8, 0};  // too short to debounce
    exp_cols[0] = 4'b1101;
    exp_cols[1] = 4'b1011;
    exp_cols[2] = 4'b0111;
    exp_cols[3] = 4'b1110;

    n_cmp  = 0;
    n_fail = 0;
    keys   = '0;
    rst_n  = 1'b0;

    // Reset state and column rotation
    step(3);
    check("rst_col_n", int'(kp.col_n), 'hE);
    check("rst_key_down", int'(kp.key_down), 0);
    check("rst_key_code", int'(kp.key_code), 0);
    check("rst_strobes", int'(b_vec), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("release_cycle_strobes", int'(b_vec), 0);
    step(4);
    check("col_after_rst", int'(kp.col_n), 'hE);
    for (int k = 0; k < 4; k++) begin
      step(8);
      check($sformatf("col_rot%0d", k), int'(kp.col_n), int'(exp_cols[k]));
    end
    take_snap();
    step(200);
    check("idle_strobes", total_delta(), 0);
    check("idle_key_down", int'(kp.key_down), 0);

    // Clean press of key 5
    take_snap();
    keys[1*4+1] = 1'b1;
    step(400);
    check("clean_b5", delta(5), 1);
    check("clean_total", total_delta(), 1);
    check("clean_code", int'(kp.key_code), 5);
    check("clean_down", int'(kp.key_down), 1);
    p = cyc;
    keys = '0;
    t = p + 2;
    while (t % 8 != 7) t++;
    found = 1'b0;
    fall_cyc = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1);
      if (!kp.key_down) begin
        found = 1'b1;
        fall_cyc = cyc;
      end
    end
    check("clean_fall_seen", int'(found), 1);
    check("clean_fall_cycle", fall_cyc, t + 17);
    check("clean_fall_col", int'(kp.col_n), 'hB);
    check("clean_code_hold", int'(kp.key_code), 5);

    // Press bounce on key F
    take_snap();
    for (int k = 0; k < 5; k++) begin
      keys[3*4+2] = 1'b1;
      step(14);
      keys = '0;
      step(20);
    end
    check("pbounce_strobes", total_delta(), 0);
    check("pbounce_down_cycles", kd_hi - kd_snap, 0);
    c0 = kp.col_n;
    step(8);
    check("pbounce_scan", int'(kp.col_n), int'({c0[2:0], c0[3]}));

    // Table of single-key presses
    for (int v = 0; v < 8; v++) begin
      take_snap();
      keys[tbl[v].row*4 + tbl[v].col] = 1'b1;
      step(tbl[v].hold);
      check($sformatf("tbl%0d_down", v), int'(kp.key_down), (tbl[v].exp_pulses != 0) ? 1 : 0);
      keys = '0;
      step(80);
      check($sformatf("tbl%0d_pulses", v), delta(int'(tbl[v].exp_code)), tbl[v].exp_pulses);
      check($sformatf("tbl%0d_total", v), total_delta(), tbl[v].exp_pulses);
      check($sformatf("tbl%0d_code", v), int'(kp.key_code), int'(tbl[v].exp_code));
      check($sformatf("tbl%0d_up", v), int'(kp.key_down), 0);
    end

    // Release bounce on key A, aligned so each open/close spans one tick
    take_snap();
    keys[0*4+3] = 1'b1;
    step(80);
    check("rbounce_down", int'(kp.key_down), 1);
    check("rbounce_code", int'(kp.key_code), 'hA);
    while (cyc % 8 != 2) step(1);
    keys[3] = 1'b0;
    step(8);
    keys[3] = 1'b1;
    step(8);
    check("rbounce_still_down", int'(kp.key_down), 1);
    keys[3] = 1'b0;
    step(21);
    check("rbounce_down_2ticks", int'(kp.key_down), 1);
    step(1);
    check("rbounce_fall", int'(kp.key_down), 0);
    check("rbounce_ba", delta(10), 1);
    check("rbounce_total", total_delta(), 1);
    step(30);

    // Two keys: 7 (row2,col0) and 3 (row0,col2), pressed while col3 is driven
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      step(1);
      if (kp.col_n == 4'b0111) found = 1'b1;
    end
    check("two_wait_col3", int'(found), 1);
    take_snap();
    keys[2*4+0] = 1'b1;
    keys[0*4+2] = 1'b1;
    step(100);
    check("two_b7", delta(7), 1);
    check("two_b3_none", delta(3), 0);
    check("two_code7", int'(kp.key_code), 7);
    keys[2*4+0] = 1'b0;
    step(150);
    check("two_b3", delta(3), 1);
    check("two_b7_once", delta(7), 1);
    check("two_code3", int'(kp.key_code), 3);
    check("two_down3", int'(kp.key_down), 1);
    keys = '0;
    step(60);

    // Reset while key 0 (row3,col1) is held
    take_snap();
    keys[3*4+1] = 1'b1;
    step(100);
    check("rh_b0", delta(0), 1);
    check("rh_code", int'(kp.key_code), 0);
    check("rh_down", int'(kp.key_down), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rh_rst_down", int'(kp.key_down), 0);
    check("rh_rst_col", int'(kp.col_n), 'hE);
    check("rh_rst_strobes", int'(b_vec), 0);
    check("rh_rst_code", int'(kp.key_code), 0);
    step(3);
    @(negedge clk);
    rst_n = 1'b1;
    take_snap();
    check("rh_release_strobes", int'(b_vec), 0);
    step(150);
    check("rh_new_b0", delta(0), 1);
    check("rh_new_total", total_delta(), 1);
    check("rh_new_down", int'(kp.key_down), 1);
    keys = '0;
    step(60);
    check("rh_up", int'(kp.key_down), 0);

    check("onehot_strobes", multi_hot, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces it and converts each accepted key press into a single-cycle pulse on one of sixteen hex-digit strobes (b_0..b_f). It sits directly upstream of the front-panel digit-entry logic, which shifts one hex digit into the display register per strobe. Each physical press yields exactly one strobe, regardless of hold time or contact bounce.

## Interface
- SCAN_DIV, 1000: clock cycles each column is driven; one row sample per dwell; minimum 4.
- DEBOUNCE_SAMPLES, 8: consecutive agreeing samples needed to accept a press or a release; minimum 1.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- row_n  in  4  keypad rows; active-low; externally pulled up; asynchronous to clk.
- col_n  out  4  column drive; exactly one bit low at all times.
- b_0 .. b_f  out  1 each  one-cycle strobe for the accepted hex key.
- key_down  out  1  high while an accepted key is held (through release debounce).
- key_code  out  4  hex value of the last accepted key; holds after release.

## Operation
- row_n passes through a 2-flop synchronizer before any use.
- Divider counts 0..SCAN_DIV-1; a sample tick is the cycle where divider = SCAN_DIV-1. All sampling happens only on ticks.
- Key map (row, col) -> hex:
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: E, 0, F, D
- States:
  - SCAN: drive column c. On a tick with no row low, advance c (3 wraps to 0). On a tick with any row low, latch the lowest-index low row as the candidate, set sample count to 1, freeze c and enter PRESS_DB.
  - PRESS_DB: on each tick, a sample with the candidate row still low increments the count; any other sample returns to SCAN and advances c. When the count reaches DEBOUNCE_SAMPLES, strobe, load key_code, set key_down and enter HELD. With DEBOUNCE_SAMPLES=1 the strobe follows the detection tick directly.
  - HELD: c stays frozen. A tick with the candidate row high sets the count to 1 and enters REL_DB. Other rows in the same column are ignored.
  - REL_DB: each tick with the candidate row high increments the count; a tick with it low returns to HELD with no strobe. When the count reaches DEBOUNCE_SAMPLES, clear key_down, advance c and enter SCAN.
- Multiple simultaneous keys:
  - Only the first key found in scan order (column, then lowest row) is tracked.
  - Other keys produce nothing until the tracked key's release completes.
  - Keys still held afterwards are detected on subsequent scans as new presses.
- Ghosting and masking are not resolved.
- Strobes: at most one of b_0..b_f is high in any cycle, each for exactly one cycle.

## Timing
- Reset values: col_n=4'b1110 (c=0), all b_*=0, key_down=0, key_code=0, state SCAN, divider and count 0, synchronizer flops 1.
- Synchronizer latency is 2 cycles. SCAN_DIV≥4 guarantees row settling after a column change.
- Strobe latency: the strobe is high in the cycle after the DEBOUNCE_SAMPLES-th agreeing tick, i.e. (DEBOUNCE_SAMPLES-1)*SCAN_DIV+1 cycles after the detection tick.
- key_code and key_down update in the same cycle as the strobe.
- key_down falls in the cycle after the DEBOUNCE_SAMPLES-th release tick. col_n advances in that same cycle.
- The divider free-runs through every state; state changes never reset it.
- Asserting rst_n low in any state immediately clears all outputs to their reset values. No strobe may fire in the reset-release cycle.

## Test plan
All scenarios use SCAN_DIV=8, DEBOUNCE_SAMPLES=3.
- Reset: hold rst_n low, then release -> col_n=1110, key_down=0, key_code=0, no strobes for 200 idle cycles; col_n rotates 1110→1101→1011→0111→1110 every 8 cycles.
- Clean press: close (row1,col1) for 400 cycles -> exactly one b_5 pulse, key_code=5, key_down=1 while held. After opening, key_down falls 17 cycles after the first high tick.
- Press bounce: close (row3,col2) for 2 ticks only, repeated 5 times -> no strobe, key_down stays 0, scanning continues.
- Release bounce: hold key A (row0,col3), then open for 1 tick, close for 1 tick, then open -> single b_a pulse, no second strobe, key_down falls only after 3 consecutive open ticks.
- Two keys: close row2 in col0 and row0 in col2 together -> b_7 only. Release key 7 while holding 3 -> b_3 pulse follows on a later scan.
- Reset while held: assert rst_n mid-HELD with key 0 (row3,col1) held, then release reset -> outputs cleared immediately, then one new b_0 pulse once re-debounced.
